// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: request/status bundle between the requesting logic and fifo_ctrl.
// Signal suffixes are relative to the controller (slave) side.
interface fifo_ctrl_if #(parameter int DEPTH = 8, parameter int AW = $clog2(DEPTH), parameter int CW = AW + 1);
   logic          clear_i;
   logic          wr_en_i;
   logic          rd_en_i;
   logic [2:0]    state_o;
   logic [AW-1:0] head_o;
   logic [AW-1:0] tail_o;
   logic [CW-1:0] data_count_o;
   logic [AW-1:0] wr_addr_o;
   logic [AW-1:0] rd_addr_o;
   logic          we_o;
   logic          re_o;
   logic          wr_ack_o;
   logic          rd_ack_o;
   logic          wr_err_o;
   logic          rd_err_o;
   logic          full_o;
   logic          empty_o;
   modport master (
      output clear_i, wr_en_i, rd_en_i,
      input  state_o, head_o, tail_o, data_count_o, wr_addr_o, rd_addr_o,
             we_o, re_o, wr_ack_o, rd_ack_o, wr_err_o, rd_err_o, full_o, empty_o
   );
   modport slave (
      input  clear_i, wr_en_i, rd_en_i,
      output state_o, head_o, tail_o, data_count_o, wr_addr_o, rd_addr_o,
             we_o, re_o, wr_ack_o, rd_ack_o, wr_err_o, rd_err_o, full_o, empty_o
   );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: arbitrating sequencer owning head/tail/count of an 8-entry register-file FIFO.
// One operation per cycle; simultaneous legal requests alternate round-robin.
module fifo_ctrl #(parameter int DEPTH = 8, parameter int AW = $clog2(DEPTH), parameter int CW = AW + 1) (
   input logic       clk_i,
   input logic       reset_n_i,
   fifo_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      INIT = 3'b000, NO_OP = 3'b001, WRITE = 3'b010, WR_ERROR = 3'b011, READ = 3'b100, RD_ERROR = 3'b101
   } state_e;
   state_e        state_q, state_d;
   logic [AW-1:0] head_q, head_d, tail_q, tail_d, wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [CW-1:0] count_q, count_d;
   logic          last_wr_q, last_wr_d;
   logic          full, empty, wr_ok, rd_ok, grant_wr, grant_rd;
   assign full     = count_q == CW'(DEPTH);
   assign empty    = count_q == '0;
   assign wr_ok    = bus.wr_en_i && !full;
   assign rd_ok    = bus.rd_en_i && !empty;
   // on a legal tie, write wins unless it won last time
   assign grant_wr = wr_ok && (!rd_ok || !last_wr_q);
   assign grant_rd = rd_ok && !grant_wr;
   always_comb begin
      state_d   = state_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      wr_addr_d = wr_addr_q;
      rd_addr_d = rd_addr_q;
      last_wr_d = last_wr_q;
      if (state_q == INIT || state_q > RD_ERROR) begin
         state_d = NO_OP;
      end else if (bus.clear_i) begin
         state_d = INIT;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else if (grant_wr) begin
         state_d   = WRITE;
         wr_addr_d = tail_q;
         tail_d    = tail_q + AW'(1);
         count_d   = count_q + CW'(1);
         last_wr_d = 1'b1;
      end else if (grant_rd) begin
         state_d   = READ;
         rd_addr_d = head_q;
         head_d    = head_q + AW'(1);
         count_d   = count_q - CW'(1);
         last_wr_d = 1'b0;
      end else begin
         state_d = bus.wr_en_i ? WR_ERROR : bus.rd_en_i ? RD_ERROR : NO_OP;
      end
   end
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= INIT;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         wr_addr_q <= '0;
         rd_addr_q <= '0;
         last_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
         last_wr_q <= last_wr_d;
      end
   end
   assign bus.state_o      = state_q;
   assign bus.head_o       = head_q;
   assign bus.tail_o       = tail_q;
   assign bus.data_count_o = count_q;
   assign bus.wr_addr_o    = wr_addr_q;
   assign bus.rd_addr_o    = rd_addr_q;
   assign bus.we_o         = state_q == WRITE;
   assign bus.wr_ack_o     = state_q == WRITE;
   assign bus.re_o         = state_q == READ;
   assign bus.rd_ack_o     = state_q == READ;
   assign bus.wr_err_o     = state_q == WR_ERROR;
   assign bus.rd_err_o     = state_q == RD_ERROR;
   assign bus.full_o       = full;
   assign bus.empty_o      = empty;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench; a queue-of-addresses FIFO model predicts every cycle's outputs.
module tb_fifo_ctrl;
   localparam int DEPTH = 8;
   typedef struct {
      int st; int hd; int tl; int cnt; int wa; int ra;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   exp_t sbq[$];
   int   mq[$];
   int   mstate = 0, wt = 0, rt = 0, waddr = 0, raddr = 0;
   bit   lastw = 1'b0;
   fifo_ctrl_if #(.DEPTH(DEPTH)) bus ();
   fifo_ctrl #(.DEPTH(DEPTH)) dut (.clk_i(clk), .reset_n_i(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, req, $time);
      end
   endtask
   // behavioural model: FIFO contents are the addresses they were written to
   task automatic drive(input bit w, input bit r, input bit c);
      exp_t e;
      bit wok, rok;
      bus.wr_en_i = w;
      bus.rd_en_i = r;
      bus.clear_i = c;
      wok = w && mq.size() < DEPTH;
      rok = r && mq.size() > 0;
      if (mstate == 0) mstate = 1;
      else if (c) begin
         mstate = 0; mq.delete(); wt = 0; rt = 0;
      end else if (wok && (!rok || !lastw)) begin
         mstate = 2; waddr = wt; mq.push_back(wt); wt = (wt + 1) % DEPTH; lastw = 1;
      end else if (rok) begin
         mstate = 4; raddr = mq.pop_front(); rt = (rt + 1) % DEPTH; lastw = 0;
      end else mstate = w ? 3 : r ? 5 : 1;
      e.st = mstate; e.hd = rt; e.tl = wt; e.cnt = mq.size(); e.wa = waddr; e.ra = raddr;
      sbq.push_back(e);
      @(negedge clk);
   endtask
   task automatic model_reset();
      mq.delete(); mstate = 0; wt = 0; rt = 0; waddr = 0; raddr = 0; lastw = 0;
   endtask
   task automatic check_reset_values();
      chk("rst_state", bus.state_o, 0);
      chk("rst_head", bus.head_o, 0);
      chk("rst_tail", bus.tail_o, 0);
      chk("rst_count", bus.data_count_o, 0);
      chk("rst_wr_addr", bus.wr_addr_o, 0);
      chk("rst_rd_addr", bus.rd_addr_o, 0);
      chk("rst_enables", {bus.we_o, bus.re_o, bus.wr_ack_o, bus.rd_ack_o, bus.wr_err_o, bus.rd_err_o}, 0);
      chk("rst_empty", bus.empty_o, 1);
      chk("rst_full", bus.full_o, 0);
   endtask
   task automatic rand_phase(input int n);
      for (int i = 0; i < n; i++) begin
         int wb;
         wb = ((i / 20) % 2) ? 80 : 25;
         drive($urandom_range(99) < wb, $urandom_range(99) < 100 - wb + 10, $urandom_range(99) < 2);
      end
   endtask
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("state", bus.state_o, e.st);
            chk("head", bus.head_o, e.hd);
            chk("tail", bus.tail_o, e.tl);
            chk("data_count", bus.data_count_o, e.cnt);
            chk("full", bus.full_o, e.cnt == DEPTH);
            chk("empty", bus.empty_o, e.cnt == 0);
            chk("we_ack", {bus.we_o, bus.wr_ack_o}, {2{e.st == 2}});
            chk("re_ack", {bus.re_o, bus.rd_ack_o}, {2{e.st == 4}});
            chk("wr_err", bus.wr_err_o, e.st == 3);
            chk("rd_err", bus.rd_err_o, e.st == 5);
            if (e.st == 2) chk("wr_addr", bus.wr_addr_o, e.wa);
            if (e.st == 4) chk("rd_addr", bus.rd_addr_o, e.ra);
         end
      end
   end
   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
   initial begin : stim
      bus.wr_en_i = 0;
      bus.rd_en_i = 0;
      bus.clear_i = 0;
      repeat (2) @(negedge clk);
      check_reset_values();
      rst_n = 1'b1;
      model_reset();
      repeat (3) drive(0, 0, 0);
      repeat (9) drive(1, 0, 0);
      repeat (9) drive(0, 1, 0);
      repeat (3) drive(1, 0, 0);
      repeat (4) drive(1, 1, 0);
      repeat (5) drive(1, 0, 0);
      drive(1, 1, 0);
      drive(1, 0, 0);
      repeat (8) drive(0, 1, 0);
      drive(1, 1, 0);
      repeat (4) drive(1, 0, 0);
      drive(0, 0, 1);
      repeat (2) drive(0, 0, 0);
      rand_phase(300);
      #2 rst_n = 1'b0;
      #1 check_reset_values();
      #1 rst_n = 1'b1;
      model_reset();
      drive(0, 0, 0);
      rand_phase(300);
      repeat (3) drive(0, 0, 0);
      @(posedge clk);
      #3;
      chk("scoreboard_drained", 8'(sbq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
